spike_aer_encoder: RTL and testbench

SPIKE_AER_ENCODER -- requirements
Module: spike_aer_encoder

---
 rtl/spike_aer_encoder.sv | 148 ++++++++++++++
 tb/tb_spike_aer_encoder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_aer_encoder.sv
// spike_aer_encoder
// Turns per-timestep spike flag vectors into a serial stream of address events.
// A step_done pulse samples the spike vector together with the current
// timestep; the latched mask is then emitted one set bit at a time, lowest
// neuron index first, each event tagged with its sample's timestep.
//
// Event handshake: an event is offered while ev_valid is high and is
// transferred on a rising clk edge where ev_valid && ev_ready. While ev_valid
// is high and ev_ready is low, ev_addr, ev_ts and ev_last are held stable.
// ev_valid never depends on ev_ready.
//
// FSM state is visible externally through busy (high exactly in SEND).
module spike_aer_encoder #(
  parameter int NUM_NEURONS = 8,
  parameter int ADDR_W      = 3,
  parameter int TS_W        = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   step_done,
  input  logic [NUM_NEURONS-1:0] spikes,
  input  logic                   clr_overrun,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [ADDR_W-1:0]      ev_addr,
  output logic [TS_W-1:0]        ev_ts,
  output logic                   ev_last,
  output logic                   busy,
  output logic                   overrun
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_NEURONS-1:0] mask_q, mask_d;
  logic [TS_W-1:0]        ts_q, ts_d;
  logic [TS_W-1:0]        cnt_q, cnt_d;
  logic                   ovr_q, ovr_d;

  logic [ADDR_W-1:0]      low_idx;
  logic                   low_found;
  logic [NUM_NEURONS-1:0] mask_pop;
  logic                   one_left;
  logic                   send;
  logic                   fire;
  logic                   last_acc;
  logic                   ovr_set;

  // Lowest set index of the pending mask: the neuron currently presented.
  always_comb begin
    low_idx   = '0;
    low_found = 1'b0;
    for (int k = 0; k < NUM_NEURONS; k++) begin
      if (mask_q[k] && !low_found) begin
        low_idx   = ADDR_W'(k);
        low_found = 1'b1;
      end
    end
  end

  // Clearing the lowest set bit gives the mask after the current event leaves;
  // if that is empty, the current event is the last of its sample.
  assign mask_pop = mask_q & (mask_q - NUM_NEURONS'(1));
  assign one_left = (mask_q != '0) && (mask_pop == '0);

  // Outputs are forced to zero for the whole reset cycle, not just after it.
  assign send     = (state_q == S_SEND);
  assign ev_valid = send && !reset;
  assign busy     = send && !reset;
  assign ev_last  = ev_valid && one_left;
  assign ev_addr  = reset ? '0 : low_idx;
  assign ev_ts    = reset ? '0 : ts_q;
  assign overrun  = ovr_q;

  assign fire     = ev_valid && ev_ready;
  assign last_acc = fire && one_left;

  // Next-state: sampling, event retirement, drop detection and timestep count.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    ts_d    = ts_q;
    cnt_d   = step_done ? (cnt_q + TS_W'(1)) : cnt_q;
    ovr_set = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (step_done) begin
          mask_d  = spikes;
          ts_d    = cnt_q;
          state_d = (spikes != '0) ? S_SEND : S_IDLE;
        end
      end
      S_SEND: begin
        if (fire) begin
          mask_d = mask_pop;
          if (one_left) begin
            state_d = S_IDLE;
          end
        end
        // A sample arriving as the burst finishes is taken as a fresh sample;
        // any other sample during a burst is dropped and flagged.
        if (step_done) begin
          if (last_acc) begin
            mask_d  = spikes;
            ts_d    = cnt_q;
            state_d = (spikes != '0) ? S_SEND : S_IDLE;
          end else begin
            ovr_set = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A new drop beats a simultaneous clear.
    if (ovr_set) begin
      ovr_d = 1'b1;
    end else if (clr_overrun) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // State registers; reset discards any burst in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      ts_q    <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      ts_q    <= ts_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Bench for spike_aer_encoder. Two instances share all inputs: one with the
// default 16-bit timestep and one with a 4-bit timestep to exercise wrap.
// A queue-based model predicts the event stream; a compare process checks
// both instances every cycle, and directed steps pin literal values.
module tb_spike_aer_encoder;

  localparam int N = 8;
  localparam int A = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         step_done;
  logic [N-1:0] spikes;
  logic         clr_overrun;
  logic         ev_ready;

  logic         ev_valid_a, ev_last_a, busy_a, overrun_a;
  logic [A-1:0] ev_addr_a;
  logic [15:0]  ev_ts_a;

  logic         ev_valid_b, ev_last_b, busy_b, overrun_b;
  logic [A-1:0] ev_addr_b;
  logic [3:0]   ev_ts_b;

  spike_aer_encoder #(.NUM_NEURONS(N), .ADDR_W(A), .TS_W(16)) u_dut (
    .clk(clk), .reset(reset), .step_done(step_done), .spikes(spikes),
    .clr_overrun(clr_overrun), .ev_valid(ev_valid_a), .ev_ready(ev_ready),
    .ev_addr(ev_addr_a), .ev_ts(ev_ts_a), .ev_last(ev_last_a),
    .busy(busy_a), .overrun(overrun_a)
  );

  spike_aer_encoder #(.NUM_NEURONS(N), .ADDR_W(A), .TS_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .step_done(step_done), .spikes(spikes),
    .clr_overrun(clr_overrun), .ev_valid(ev_valid_b), .ev_ready(ev_ready),
    .ev_addr(ev_addr_b), .ev_ts(ev_ts_b), .ev_last(ev_last_b),
    .busy(busy_b), .overrun(overrun_b)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: pending events of the current sample as a queue of addresses,
  // the sample's timestep, an unbounded step counter and the sticky flag.
  logic [A-1:0] exp_q[$];
  int           m_cnt   = 0;
  int           m_ts    = 0;
  bit           m_ovr   = 1'b0;
  bit           started = 1'b0;

  always @(posedge clk) begin
    bit drop;
    started = 1'b1;
    drop    = 1'b0;
    if (reset) begin
      exp_q.delete();
      m_cnt = 0;
      m_ts  = 0;
      m_ovr = 1'b0;
    end else begin
      if (exp_q.size() > 0 && ev_ready) void'(exp_q.pop_front());
      if (step_done) begin
        if (exp_q.size() == 0) begin
          m_ts = m_cnt;
          for (int k = 0; k < N; k++) if (spikes[k]) exp_q.push_back(A'(k));
        end else begin
          drop = 1'b1;
        end
        m_cnt++;
      end
      if (drop) m_ovr = 1'b1;
      else if (clr_overrun) m_ovr = 1'b0;
    end
  end

  // Compare process: both instances against the model, every cycle.
  always @(negedge clk) begin
    bit ev;
    if (started) begin
      ev = !reset && (exp_q.size() > 0);
      chk("valid_a",   32'(ev_valid_a), 32'(ev));
      chk("busy_a",    32'(busy_a),     32'(ev));
      chk("overrun_a", 32'(overrun_a),  32'(m_ovr));
      chk("last_a",    32'(ev_last_a),  32'(ev && exp_q.size() == 1));
      chk("valid_b",   32'(ev_valid_b), 32'(ev));
      chk("busy_b",    32'(busy_b),     32'(ev));
      chk("overrun_b", 32'(overrun_b),  32'(m_ovr));
      chk("last_b",    32'(ev_last_b),  32'(ev && exp_q.size() == 1));
      if (ev) begin
        chk("addr_a", 32'(ev_addr_a), 32'(exp_q[0]));
        chk("ts_a",   32'(ev_ts_a),   32'(m_ts & 32'hffff));
        chk("addr_b", 32'(ev_addr_b), 32'(exp_q[0]));
        chk("ts_b",   32'(ev_ts_b),   32'(m_ts & 32'hf));
      end else if (reset) begin
        chk("addr_rst", 32'(ev_addr_a), 32'd0);
        chk("ts_rst",   32'(ev_ts_a),   32'd0);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic sd, input logic [N-1:0] sp,
                      input logic rdy, input logic clr);
    step_done   = sd;
    spikes      = sp;
    ev_ready    = rdy;
    clr_overrun = clr;
    @(posedge clk);
    #1;
  endtask

  // Literal check of the main instance's event outputs.
  task automatic lit_ev(input string name, input logic v, input int addr,
                        input int ts, input logic last);
    chk({name, "_valid"}, 32'(ev_valid_a), 32'(v));
    if (v) begin
      chk({name, "_addr"}, 32'(ev_addr_a), 32'(addr));
      chk({name, "_ts"},   32'(ev_ts_a),   32'(ts));
      chk({name, "_last"}, 32'(ev_last_a), 32'(last));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset       = 1'b1;
    step_done   = 1'b0;
    spikes      = '0;
    clr_overrun = 1'b0;
    ev_ready    = 1'b0;
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 8'hff, 1'b1, 1'b0);
    chk("rst_valid",   32'(ev_valid_a), 32'd0);
    chk("rst_busy",    32'(busy_a),     32'd0);
    chk("rst_last",    32'(ev_last_a),  32'd0);
    chk("rst_overrun", 32'(overrun_a),  32'd0);
    chk("rst_addr",    32'(ev_addr_a),  32'd0);
    chk("rst_ts",      32'(ev_ts_a),    32'd0);
    reset = 1'b0;

    // Three back-to-back events, ascending, last flagged on neuron 5.
    step(1'b1, 8'b0010_0101, 1'b1, 1'b0);
    lit_ev("b3_e0", 1'b1, 0, 0, 1'b0);
    step(1'b0, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
    lit_ev("b3_e1", 1'b1, 2, 0, 1'b0);
    step(1'b0, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
    lit_ev("b3_e2", 1'b1, 5, 0, 1'b1);
    step(1'b0, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
    lit_ev("b3_end", 1'b0, 0, 0, 1'b0);

    // Stalled consumer holds the event; release drains 0 then 7.
    step(1'b1, 8'b1000_0001, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      lit_ev("stall", 1'b1, 0, 1, 1'b0);
      if (i < 3) step(1'b0, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    end
    ev_ready = 1'b1;
    lit_ev("rel_e0", 1'b1, 0, 1, 1'b0);
    step(1'b0, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
    lit_ev("rel_e1", 1'b1, 7, 1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    lit_ev("rel_end", 1'b0, 0, 0, 1'b0);

    // Empty samples produce nothing but still advance the timestep.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, '0, 1'b1, 1'b0);
      lit_ev("zero", 1'b0, 0, 0, 1'b0);
    end
    step(1'b1, 8'h10, 1'b1, 1'b0);
    lit_ev("after_zero", 1'b1, 4, 3, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    lit_ev("after_zero_end", 1'b0, 0, 0, 1'b0);

    // Overrun: drop during a stall, clear, then clear racing a new drop.
    step(1'b1, 8'h03, 1'b0, 1'b0);
    lit_ev("ovr_e0", 1'b1, 0, 4, 1'b0);
    step(1'b1, 8'hff, 1'b0, 1'b0);
    chk("ovr_set", 32'(overrun_a), 32'd1);
    lit_ev("ovr_hold", 1'b1, 0, 4, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("ovr_clr", 32'(overrun_a), 32'd0);
    step(1'b1, 8'h40, 1'b0, 1'b1);
    chk("ovr_set_wins", 32'(overrun_a), 32'd1);
    step(1'b0, '0, 1'b1, 1'b0);
    lit_ev("ovr_e1", 1'b1, 1, 4, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    lit_ev("ovr_end", 1'b0, 0, 0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    chk("ovr_clr2", 32'(overrun_a), 32'd0);

    // New sample arriving on the final handshake is accepted, not dropped.
    step(1'b1, 8'h01, 1'b1, 1'b0);
    lit_ev("fin_e0", 1'b1, 0, 7, 1'b1);
    step(1'b1, 8'h02, 1'b1, 1'b0);
    chk("fin_no_ovr", 32'(overrun_a), 32'd0);
    lit_ev("fin_e1", 1'b1, 1, 8, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    lit_ev("fin_end", 1'b0, 0, 0, 1'b0);

    // Timestep wrap: 16 pulses bring the 4-bit counter back to 0.
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, '0, 1'b1, 1'b0);
    step(1'b1, 8'h01, 1'b1, 1'b0);
    lit_ev("wrap_a", 1'b1, 0, 16, 1'b1);
    chk("wrap_b_ts",    32'(ev_ts_b),    32'd0);
    chk("wrap_b_valid", 32'(ev_valid_b), 32'd1);
    step(1'b0, '0, 1'b1, 1'b0);

    // Reset in the middle of a stalled burst discards it.
    step(1'b1, 8'hff, 1'b0, 1'b0);
    lit_ev("mid_e0", 1'b1, 0, 17, 1'b0);
    reset = 1'b1;
    step(1'b1, 8'h0f, 1'b1, 1'b1);
    reset = 1'b0;
    chk("mid_valid", 32'(ev_valid_a), 32'd0);
    chk("mid_busy",  32'(busy_a),     32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
      chk("mid_quiet", 32'(ev_valid_a), 32'd0);
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
